// File: rtl/red_pitaya_acq_ch_multi_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : red_pitaya_acq_ch_multi_seg_pkg
// Purpose : Shared definitions for the multi-segment acquisition channel:
//           FSM state encoding, trigger source codes, the external-trigger
//           lockout length and a trigger-source select helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package red_pitaya_acq_ch_multi_seg_pkg;

    typedef enum logic [1:0] {
        ACQ_IDLE    = 2'd0,
        ACQ_ARMED   = 2'd1,
        ACQ_CAPTURE = 2'd2,
        ACQ_SEG_END = 2'd3
    } acq_state_e;

    localparam logic [2:0] TRIG_SRC_SW     = 3'd1;
    localparam logic [2:0] TRIG_SRC_EXT_PE = 3'd2;
    localparam logic [2:0] TRIG_SRC_EXT_NE = 3'd3;

    // Cycles during which further edges of the same polarity are ignored
    localparam int unsigned TRIG_DEBOUNCE = 62500;

    function automatic logic trig_select(
        input logic [2:0] src,
        input logic       sw,
        input logic       ext_pe,
        input logic       ext_ne
    );
        case (src)
            TRIG_SRC_SW:     return sw;
            TRIG_SRC_EXT_PE: return ext_pe;
            TRIG_SRC_EXT_NE: return ext_ne;
            default:         return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/red_pitaya_trig_debounce.sv
`default_nettype none
// ============================================================================
// Module  : red_pitaya_trig_debounce
// Purpose : Synchronises an asynchronous trigger line (3 flops), detects
//           rising/falling edges and emits one-cycle pulses, each polarity
//           with its own lockout window after an accepted edge.
// Ports   : clk     - sampling clock
//           rst_n   - asynchronous active-low reset
//           i_clr   - synchronous clear of lockout counters and pulses
//           i_trig  - asynchronous trigger input
//           o_pos   - rising-edge pulse (registered)
//           o_neg   - falling-edge pulse (registered)
// Rev     : 1.0  initial release
// ============================================================================
module red_pitaya_trig_debounce
    import red_pitaya_acq_ch_multi_seg_pkg::*;
#(
    parameter int unsigned LOCKOUT = TRIG_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_trig,
    output logic o_pos,
    output logic o_neg
);

    localparam int unsigned CNT_W = $clog2(LOCKOUT + 1);

    logic [2:0]       sync_q, sync_d;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] pos_cnt_q, pos_cnt_d;
    logic [CNT_W-1:0] neg_cnt_q, neg_cnt_d;
    logic             pos_q, pos_d;
    logic             neg_q, neg_d;
    logic             rise, fall;

    always_comb begin
        sync_d    = {sync_q[1:0], i_trig};
        lvl_d     = sync_q[2];
        rise      = sync_q[2] & ~lvl_q;
        fall      = ~sync_q[2] & lvl_q;
        pos_d     = 1'b0;
        neg_d     = 1'b0;
        pos_cnt_d = (pos_cnt_q != '0) ? pos_cnt_q - 1'b1 : pos_cnt_q;
        neg_cnt_d = (neg_cnt_q != '0) ? neg_cnt_q - 1'b1 : neg_cnt_q;
        // An edge is accepted only once the previous lockout has fully expired
        if (rise && (pos_cnt_q == '0)) begin
            pos_d     = 1'b1;
            pos_cnt_d = CNT_W'(LOCKOUT);
        end
        if (fall && (neg_cnt_q == '0)) begin
            neg_d     = 1'b1;
            neg_cnt_d = CNT_W'(LOCKOUT);
        end
        // Clearing leaves the synchroniser alone so no false edge is created
        if (i_clr) begin
            pos_d     = 1'b0;
            neg_d     = 1'b0;
            pos_cnt_d = '0;
            neg_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            lvl_q     <= 1'b0;
            pos_cnt_q <= '0;
            neg_cnt_q <= '0;
            pos_q     <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            lvl_q     <= lvl_d;
            pos_cnt_q <= pos_cnt_d;
            neg_cnt_q <= neg_cnt_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
        end
    end

    assign o_pos = pos_q;
    assign o_neg = neg_q;

endmodule
`default_nettype wire

// File: rtl/red_pitaya_acq_ch_multi_seg.sv
`default_nettype none
// ============================================================================
// Module  : red_pitaya_acq_ch_multi_seg
// Purpose : ADC capture channel writing decimated samples into a local
//           simple dual-port RAM as up to N_SEG independently triggered
//           segments; software reads the RAM back with 1-cycle latency.
// Ports   : adc_clk_i/adc_rstn_i        clock, async active-low reset
//           adc_dat_i                   ADC sample (two's complement)
//           trig_sw_i/trig_ext_i        software / async external trigger
//           trig_src_i                  1 sw, 2 ext rise, 3 ext fall
//           set_arm_i/set_rst_i         arm pulse / synchronous FSM reset
//           set_nseg_i                  segments minus one
//           set_start/len/dec_all_i     packed per-segment descriptors
//           buf_addr_i/buf_rdata_o      read-back port
//           buf_wpnt_o, seg_idx_o, busy_o, seg_done_o, acq_done_o,
//           trig_miss_o                 status
// Rev     : 1.0  initial release
// ============================================================================
module red_pitaya_acq_ch_multi_seg
    import red_pitaya_acq_ch_multi_seg_pkg::*;
#(
    parameter  int unsigned RSZ   = 14,
    parameter  int unsigned N_SEG = 4,
    localparam int unsigned SW    = (N_SEG > 1) ? $clog2(N_SEG) : 1
) (
    input  logic                     adc_clk_i,
    input  logic                     adc_rstn_i,
    input  logic [13:0]              adc_dat_i,
    input  logic                     trig_sw_i,
    input  logic                     trig_ext_i,
    input  logic [2:0]               trig_src_i,
    input  logic                     set_arm_i,
    input  logic                     set_rst_i,
    input  logic [SW-1:0]            set_nseg_i,
    input  logic [RSZ*N_SEG-1:0]     set_start_all_i,
    input  logic [(RSZ+1)*N_SEG-1:0] set_len_all_i,
    input  logic [17*N_SEG-1:0]      set_dec_all_i,
    input  logic [RSZ-1:0]           buf_addr_i,
    output logic [13:0]              buf_rdata_o,
    output logic [RSZ-1:0]           buf_wpnt_o,
    output logic [SW-1:0]            seg_idx_o,
    output logic                     busy_o,
    output logic                     seg_done_o,
    output logic                     acq_done_o,
    output logic [15:0]              trig_miss_o
);

    // ------------------------------------------------------------------
    // Descriptor unpacking
    // ------------------------------------------------------------------
    logic [RSZ-1:0] seg_start [N_SEG];
    logic [RSZ:0]   seg_len   [N_SEG];
    logic [16:0]    seg_dec   [N_SEG];

    for (genvar gi = 0; gi < N_SEG; gi++) begin : g_seg
        assign seg_start[gi] = set_start_all_i[gi*RSZ     +: RSZ];
        assign seg_len[gi]   = set_len_all_i  [gi*(RSZ+1) +: RSZ+1];
        assign seg_dec[gi]   = set_dec_all_i  [gi*17      +: 17];
    end

    // ------------------------------------------------------------------
    // Input registers and trigger path
    // ------------------------------------------------------------------
    logic ext_pe, ext_ne;

    red_pitaya_trig_debounce #(
        .LOCKOUT (TRIG_DEBOUNCE)
    ) u_trig_debounce (
        .clk    (adc_clk_i),
        .rst_n  (adc_rstn_i),
        .i_clr  (set_rst_i),
        .i_trig (trig_ext_i),
        .o_pos  (ext_pe),
        .o_neg  (ext_ne)
    );

    logic [13:0] adc_r_q, adc_r_d;
    logic        trig_in_q, trig_in_d;

    // ------------------------------------------------------------------
    // Capture state
    // ------------------------------------------------------------------
    acq_state_e     state_q, state_d;
    logic [SW-1:0]  seg_idx_q, seg_idx_d;
    logic [RSZ-1:0] start_q, start_d;
    logic [RSZ:0]   len_q, len_d;
    logic [16:0]    dec_q, dec_d;
    logic [16:0]    dec_cnt_q, dec_cnt_d;
    logic [RSZ:0]   wcnt_q, wcnt_d;
    logic [RSZ-1:0] wpnt_q, wpnt_d;
    logic           seg_done_q, seg_done_d;
    logic           acq_done_q, acq_done_d;
    logic [15:0]    trig_miss_q, trig_miss_d;

    logic           wr_en;
    logic [RSZ-1:0] wr_addr;

    // set_rst_i also suppresses a write in the cycle it is seen
    assign wr_en   = (state_q == ACQ_CAPTURE) && (dec_cnt_q == '0) && !set_rst_i;
    assign wr_addr = start_q + wcnt_q[RSZ-1:0];

    always_comb begin
        adc_r_d     = adc_dat_i;
        trig_in_d   = trig_select(trig_src_i, trig_sw_i, ext_pe, ext_ne);
        state_d     = state_q;
        seg_idx_d   = seg_idx_q;
        start_d     = start_q;
        len_d       = len_q;
        dec_d       = dec_q;
        dec_cnt_d   = dec_cnt_q;
        wcnt_d      = wcnt_q;
        wpnt_d      = wpnt_q;
        seg_done_d  = 1'b0;
        acq_done_d  = 1'b0;
        trig_miss_d = trig_miss_q;

        if (((state_q == ACQ_CAPTURE) || (state_q == ACQ_SEG_END)) && trig_in_q
                && (trig_miss_q != 16'hFFFF)) begin
            trig_miss_d = trig_miss_q + 16'd1;
        end

        case (state_q)
            ACQ_IDLE: begin
                if (set_arm_i) begin
                    state_d     = ACQ_ARMED;
                    seg_idx_d   = '0;
                    trig_miss_d = '0;
                end
            end
            ACQ_ARMED: begin
                if (trig_in_q) begin
                    // Freeze the descriptor so SW edits cannot disturb this segment
                    state_d   = ACQ_CAPTURE;
                    start_d   = seg_start[seg_idx_q];
                    len_d     = (seg_len[seg_idx_q] == '0) ? (RSZ+1)'(1) : seg_len[seg_idx_q];
                    dec_d     = (seg_dec[seg_idx_q] == '0) ? 17'd1 : seg_dec[seg_idx_q];
                    dec_cnt_d = '0;
                    wcnt_d    = '0;
                end
            end
            ACQ_CAPTURE: begin
                dec_cnt_d = (dec_cnt_q == dec_q - 17'd1) ? 17'd0 : dec_cnt_q + 17'd1;
                if (wr_en) begin
                    wpnt_d = wr_addr;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_d == len_q) begin
                        state_d    = ACQ_SEG_END;
                        seg_done_d = 1'b1;
                        // Also stop at the last descriptor if nseg points past it
                        acq_done_d = (seg_idx_q >= set_nseg_i) || (seg_idx_q == SW'(N_SEG - 1));
                    end
                end
            end
            ACQ_SEG_END: begin
                // acq_done_q was decided on the last write; reuse it so the
                // pulse and the branch always agree
                if (acq_done_q) begin
                    state_d = ACQ_IDLE;
                end else begin
                    state_d   = ACQ_ARMED;
                    seg_idx_d = seg_idx_q + 1'b1;
                end
            end
            default: state_d = ACQ_IDLE;
        endcase

        if (set_rst_i) begin
            adc_r_d     = '0;
            trig_in_d   = 1'b0;
            state_d     = ACQ_IDLE;
            seg_idx_d   = '0;
            start_d     = '0;
            len_d       = '0;
            dec_d       = '0;
            dec_cnt_d   = '0;
            wcnt_d      = '0;
            wpnt_d      = '0;
            seg_done_d  = 1'b0;
            acq_done_d  = 1'b0;
            trig_miss_d = '0;
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            adc_r_q     <= '0;
            trig_in_q   <= 1'b0;
            state_q     <= ACQ_IDLE;
            seg_idx_q   <= '0;
            start_q     <= '0;
            len_q       <= '0;
            dec_q       <= '0;
            dec_cnt_q   <= '0;
            wcnt_q      <= '0;
            wpnt_q      <= '0;
            seg_done_q  <= 1'b0;
            acq_done_q  <= 1'b0;
            trig_miss_q <= '0;
        end else begin
            adc_r_q     <= adc_r_d;
            trig_in_q   <= trig_in_d;
            state_q     <= state_d;
            seg_idx_q   <= seg_idx_d;
            start_q     <= start_d;
            len_q       <= len_d;
            dec_q       <= dec_d;
            dec_cnt_q   <= dec_cnt_d;
            wcnt_q      <= wcnt_d;
            wpnt_q      <= wpnt_d;
            seg_done_q  <= seg_done_d;
            acq_done_q  <= acq_done_d;
            trig_miss_q <= trig_miss_d;
        end
    end

    // ------------------------------------------------------------------
    // Sample buffer: simple dual-port, read-first on address collision
    // ------------------------------------------------------------------
    logic [13:0] mem [2**RSZ];
    logic [13:0] rdata_q;

    always_ff @(posedge adc_clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= adc_r_q;
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            rdata_q <= '0;
        end else if (set_rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[buf_addr_i];
        end
    end

    assign buf_rdata_o = rdata_q;
    assign buf_wpnt_o  = wpnt_q;
    assign seg_idx_o   = seg_idx_q;
    assign busy_o      = (state_q != ACQ_IDLE);
    assign seg_done_o  = seg_done_q;
    assign acq_done_o  = acq_done_q;
    assign trig_miss_o = trig_miss_q;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_acq_ch_multi_seg.sv
`default_nettype none
// ============================================================================
// Module  : tb_red_pitaya_acq_ch_multi_seg
// Purpose : Directed self-checking bench for red_pitaya_acq_ch_multi_seg.
//           The ADC input is a ramp that steps on every falling clock edge,
//           so a sample written for a trigger raised while the ramp reads v
//           is v + 2 + i*dec (input register plus trigger register delay).
// Rev     : 1.0  initial release
// ============================================================================
module tb_red_pitaya_acq_ch_multi_seg;

    localparam int RSZ   = 14;
    localparam int N_SEG = 4;
    localparam int SW    = 2;

    logic                     clk = 1'b0;
    logic                     adc_rstn_i;
    logic [13:0]              adc_dat_i;
    logic                     trig_sw_i, trig_ext_i;
    logic [2:0]               trig_src_i;
    logic                     set_arm_i, set_rst_i;
    logic [SW-1:0]            set_nseg_i;
    logic [RSZ*N_SEG-1:0]     set_start_all_i;
    logic [(RSZ+1)*N_SEG-1:0] set_len_all_i;
    logic [17*N_SEG-1:0]      set_dec_all_i;
    logic [RSZ-1:0]           buf_addr_i;
    logic [13:0]              buf_rdata_o;
    logic [RSZ-1:0]           buf_wpnt_o;
    logic [SW-1:0]            seg_idx_o;
    logic                     busy_o, seg_done_o, acq_done_o;
    logic [15:0]              trig_miss_o;

    red_pitaya_acq_ch_multi_seg #(.RSZ(RSZ), .N_SEG(N_SEG)) dut (
        .adc_clk_i       (clk),
        .adc_rstn_i      (adc_rstn_i),
        .adc_dat_i       (adc_dat_i),
        .trig_sw_i       (trig_sw_i),
        .trig_ext_i      (trig_ext_i),
        .trig_src_i      (trig_src_i),
        .set_arm_i       (set_arm_i),
        .set_rst_i       (set_rst_i),
        .set_nseg_i      (set_nseg_i),
        .set_start_all_i (set_start_all_i),
        .set_len_all_i   (set_len_all_i),
        .set_dec_all_i   (set_dec_all_i),
        .buf_addr_i      (buf_addr_i),
        .buf_rdata_o     (buf_rdata_o),
        .buf_wpnt_o      (buf_wpnt_o),
        .seg_idx_o       (seg_idx_o),
        .busy_o          (busy_o),
        .seg_done_o      (seg_done_o),
        .acq_done_o      (acq_done_o),
        .trig_miss_o     (trig_miss_o)
    );

    always #5 clk = ~clk;

    // Ramp stimulus and a free-running cycle count
    int cyc;
    initial begin
        adc_dat_i = '0;
        cyc       = 0;
        forever begin
            @(negedge clk);
            adc_dat_i = adc_dat_i + 14'd1;
            cyc       = cyc + 1;
        end
    end

    // Pulse counters
    int seg_cnt = 0;
    int acq_cnt = 0;
    always @(negedge clk) begin
        if (seg_done_o) seg_cnt <= seg_cnt + 1;
        if (acq_done_o) acq_cnt <= acq_cnt + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_seg(input int k, input int start, input int len, input int dec);
        set_start_all_i[k*RSZ +: RSZ]         = RSZ'(start);
        set_len_all_i[k*(RSZ+1) +: RSZ+1]     = (RSZ+1)'(len);
        set_dec_all_i[k*17 +: 17]             = 17'(dec);
    endtask

    task automatic arm();
        set_arm_i = 1'b1;
        tick();
        set_arm_i = 1'b0;
    endtask

    // Returns the ramp value seen while the trigger was raised
    task automatic sw_trig(output logic [13:0] v);
        v         = adc_dat_i;
        trig_sw_i = 1'b1;
        tick();
        trig_sw_i = 1'b0;
    endtask

    task automatic rd(input int a, output logic [13:0] d);
        buf_addr_i = RSZ'(a);
        tick();
        d = buf_rdata_o;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, " idle"}, 32'(busy_o), 0);
    endtask

    task automatic wait_seg_idx(input string tag, input int k, input int budget);
        int n = 0;
        while (seg_idx_o != SW'(k) && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, " seg_idx"}, 32'(seg_idx_o), 32'(k));
    endtask

    initial begin
        logic [13:0] v, v1, v2, vf, vs, va, d;
        int          s0, a0, e0, n;

        adc_rstn_i      = 1'b0;
        trig_sw_i       = 1'b0;
        trig_ext_i      = 1'b0;
        trig_src_i      = 3'd1;
        set_arm_i       = 1'b0;
        set_rst_i       = 1'b0;
        set_nseg_i      = '0;
        set_start_all_i = '0;
        set_len_all_i   = '0;
        set_dec_all_i   = '0;
        buf_addr_i      = '0;
        repeat (4) tick();
        @(negedge clk);
        adc_rstn_i = 1'b1;
        tick();

        // Reset state
        check_eq("rst busy", 32'(busy_o), 0);
        check_eq("rst seg_idx", 32'(seg_idx_o), 0);
        check_eq("rst wpnt", 32'(buf_wpnt_o), 0);
        check_eq("rst trig_miss", 32'(trig_miss_o), 0);
        check_eq("rst seg_done", 32'(seg_done_o), 0);
        check_eq("rst acq_done", 32'(acq_done_o), 0);
        check_eq("rst rdata", 32'(buf_rdata_o), 0);

        // set_rst_i beats set_arm_i
        set_rst_i = 1'b1;
        set_arm_i = 1'b1;
        tick();
        set_rst_i = 1'b0;
        set_arm_i = 1'b0;
        check_eq("srst over arm busy", 32'(busy_o), 0);

        // A: single segment at 100, len 8, dec 1
        cfg_seg(0, 100, 8, 1);
        set_nseg_i = '0;
        s0 = seg_cnt;
        a0 = acq_cnt;
        arm();
        check_eq("A armed busy", 32'(busy_o), 1);
        repeat (3) tick();
        sw_trig(v);
        n = 0;
        while (!seg_done_o && n < 40) begin
            tick();
            n++;
        end
        check_eq("A seg_done", 32'(seg_done_o), 1);
        check_eq("A acq_done with seg_done", 32'(acq_done_o), 1);
        check_eq("A busy in seg_end", 32'(busy_o), 1);
        tick();
        check_eq("A busy drop", 32'(busy_o), 0);
        check_eq("A seg_done width", 32'(seg_done_o), 0);
        check_eq("A seg_done count", 32'(seg_cnt - s0), 1);
        check_eq("A acq_done count", 32'(acq_cnt - a0), 1);
        check_eq("A wpnt", 32'(buf_wpnt_o), 107);
        for (int i = 0; i < 8; i++) begin
            rd(100 + i, d);
            check_eq($sformatf("A ram[%0d]", 100 + i), 32'(d), 32'(14'(v + 14'(2 + i))));
        end

        // B: decimation by 4
        cfg_seg(0, 0, 4, 4);
        arm();
        tick();
        sw_trig(v);
        wait_idle("B", 100);
        for (int i = 0; i < 4; i++) begin
            rd(i, d);
            check_eq($sformatf("B ram[%0d]", i), 32'(d), 32'(14'(v + 14'(2 + 4 * i))));
        end

        // C: address wrap
        cfg_seg(0, 16382, 4, 1);
        arm();
        sw_trig(v);
        wait_idle("C", 100);
        check_eq("C wpnt", 32'(buf_wpnt_o), 1);
        rd(16382, d); check_eq("C ram[16382]", 32'(d), 32'(14'(v + 14'd2)));
        rd(16383, d); check_eq("C ram[16383]", 32'(d), 32'(14'(v + 14'd3)));
        rd(0, d);     check_eq("C ram[0]", 32'(d), 32'(14'(v + 14'd4)));
        rd(1, d);     check_eq("C ram[1]", 32'(d), 32'(14'(v + 14'd5)));

        // D: three segments, two extra triggers during the first capture
        cfg_seg(0, 0, 20, 1);
        cfg_seg(1, 1000, 20, 1);
        cfg_seg(2, 2000, 20, 1);
        set_nseg_i = 2'd2;
        s0 = seg_cnt;
        a0 = acq_cnt;
        arm();
        sw_trig(v);
        repeat (2) tick();
        trig_sw_i = 1'b1; tick(); trig_sw_i = 1'b0;
        tick();
        trig_sw_i = 1'b1; tick(); trig_sw_i = 1'b0;
        wait_seg_idx("D seg1", 1, 60);
        sw_trig(v1);
        wait_seg_idx("D seg2", 2, 60);
        sw_trig(v2);
        wait_idle("D", 60);
        check_eq("D seg_done count", 32'(seg_cnt - s0), 3);
        check_eq("D acq_done count", 32'(acq_cnt - a0), 1);
        check_eq("D trig_miss", 32'(trig_miss_o), 2);
        rd(0, d);    check_eq("D ram[0]", 32'(d), 32'(14'(v + 14'd2)));
        rd(1001, d); check_eq("D ram[1001]", 32'(d), 32'(14'(v1 + 14'd3)));
        rd(2019, d); check_eq("D ram[2019]", 32'(d), 32'(14'(v2 + 14'd21)));

        // F: fill 3000..3039, then cut captures short with set_rst_i and async reset
        cfg_seg(0, 3000, 40, 1);
        set_nseg_i = '0;
        arm();
        sw_trig(vf);
        wait_idle("F fill", 100);

        arm();
        sw_trig(vs);
        repeat (10) tick();
        set_rst_i = 1'b1;
        tick();
        set_rst_i = 1'b0;
        check_eq("F srst busy", 32'(busy_o), 0);
        check_eq("F srst wpnt", 32'(buf_wpnt_o), 0);
        repeat (5) tick();
        check_eq("F srst stays idle", 32'(busy_o), 0);
        rd(3008, d); check_eq("F srst last write", 32'(d), 32'(14'(vs + 14'd10)));
        rd(3009, d); check_eq("F srst no later write", 32'(d), 32'(14'(vf + 14'd11)));

        arm();
        sw_trig(va);
        repeat (14) tick();
        adc_rstn_i = 1'b0;
        #1;
        check_eq("F arst busy", 32'(busy_o), 0);
        check_eq("F arst wpnt", 32'(buf_wpnt_o), 0);
        check_eq("F arst seg_done", 32'(seg_done_o), 0);
        repeat (3) tick();
        @(negedge clk);
        adc_rstn_i = 1'b1;
        tick();
        rd(3012, d); check_eq("F arst last write", 32'(d), 32'(14'(va + 14'd14)));
        rd(3013, d); check_eq("F arst no later write", 32'(d), 32'(14'(vf + 14'd15)));

        // E: external rising edge, glitch inside lockout, edge after lockout
        trig_src_i = 3'd2;
        cfg_seg(0, 5000, 2, 1);
        set_nseg_i = '0;
        s0 = seg_cnt;
        arm();
        tick();
        trig_ext_i = 1'b1;
        e0 = cyc;
        wait_idle("E first edge", 50);
        check_eq("E first seg_done", 32'(seg_cnt - s0), 1);
        arm();
        while (cyc < e0 + 1000) tick();
        trig_ext_i = 1'b0;
        repeat (3) tick();
        trig_ext_i = 1'b1;
        repeat (200) tick();
        check_eq("E glitch ignored busy", 32'(busy_o), 1);
        check_eq("E glitch ignored seg_done", 32'(seg_cnt - s0), 1);
        while (cyc < e0 + 63000) tick();
        trig_ext_i = 1'b0;
        repeat (5) tick();
        trig_ext_i = 1'b1;
        wait_idle("E after lockout", 50);
        check_eq("E second seg_done", 32'(seg_cnt - s0), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
